// File: rtl/l2_config_and_types.sv
// Shared L2 configuration constants and the SRAM responder state encoding.
package l2_config_and_types;

  localparam int L2_NUM_PORTS = 2;
  localparam int L2_SUB_ID_W  = 2;
  localparam int L2_ADDR_W    = 32;
  localparam int L2_DATA_W    = 32;
  localparam int L2_BE_W      = L2_DATA_W / 8;
  localparam int L2_BURST_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    AMO_RD,
    AMO_WR
  } l2_sram_state_t;

endpackage

// File: rtl/l2_memory_interface.sv
// L2 memory protocol bundle: request, write-data and read-return channels.
interface l2_memory_interface #(
  parameter int ID_W = $clog2(l2_config_and_types::L2_NUM_PORTS) + l2_config_and_types::L2_SUB_ID_W
);
  logic [l2_config_and_types::L2_ADDR_W-1:0]  addr;
  logic [l2_config_and_types::L2_BE_W-1:0]    be;
  logic                                       rnw;
  logic                                       is_amo;
  logic [l2_config_and_types::L2_BURST_W-1:0] amo_type_or_burst_size;
  logic [ID_W-1:0]                            id;
  logic                                       request_valid;
  logic                                       abort;
  logic                                       request_pop;
  logic [l2_config_and_types::L2_DATA_W-1:0]  wr_data;
  logic                                       wr_data_valid;
  logic                                       wr_data_read;
  logic [l2_config_and_types::L2_DATA_W-1:0]  rd_data;
  logic [ID_W-1:0]                            rd_id;
  logic                                       rd_data_valid;

  modport slave (
    input  addr, be, rnw, is_amo, amo_type_or_burst_size, id,
    input  request_valid, abort, wr_data, wr_data_valid,
    output request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
  );

  modport master (
    output addr, be, rnw, is_amo, amo_type_or_burst_size, id,
    output request_valid, abort, wr_data, wr_data_valid,
    input  request_pop, wr_data_read, rd_data, rd_id, rd_data_valid
  );
endinterface

// File: rtl/l2_sram_bank.sv
// Single-port word array with byte-enable writes and a registered one-cycle read.
// Read data holds its last value until the next read; storage itself is never reset.
module l2_sram_bank #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_array [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_array[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (en && !we) rdata <= mem_array[addr];
  end

endmodule

// File: rtl/l2_sram_responder.sv
// L2 memory responder: serves read/write bursts and swap AMOs from a local SRAM bank.
// Read data returns one cycle after each array read with no backpressure; write data is pulled as offered.
module l2_sram_responder
  import l2_config_and_types::*;
#(
  parameter int L2_ID_W     = $clog2(L2_NUM_PORTS) + L2_SUB_ID_W,
  parameter int DEPTH_WORDS = 4096
) (
  input logic               clk,
  input logic               rst,
  l2_memory_interface.slave mem
);

  localparam int AW = $clog2(DEPTH_WORDS);

  l2_sram_state_t          state, state_nxt;
  logic [AW-1:0]           addr_q;
  logic [L2_BURST_W-1:0]   size_q;
  logic [L2_BURST_W-1:0]   cnt_q;
  logic [L2_ID_W-1:0]      id_q;
  logic [L2_ID_W-1:0]      rd_id_q;
  logic [L2_BE_W-1:0]      be_q;
  logic                    abort_q;
  logic                    rd_vld_q;

  logic                    pop;
  logic                    wr_take;
  logic                    ram_en;
  logic                    ram_we;
  logic                    step;
  logic                    last;
  logic [L2_DATA_W-1:0]    ram_rdata;

  assign last = (cnt_q == size_q);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_take   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (mem.request_valid) begin
          pop = 1'b1;
          // Aborted writes/AMOs still drain their data words, with writes masked.
          if (mem.abort)       state_nxt = mem.is_amo ? AMO_WR : (mem.rnw ? IDLE : WRITE);
          else if (mem.is_amo) state_nxt = AMO_RD;
          else if (mem.rnw)    state_nxt = READ;
          else                 state_nxt = WRITE;
        end
      end
      READ: begin
        ram_en = 1'b1;
        step   = 1'b1;
        if (last) state_nxt = IDLE;
      end
      WRITE: begin
        if (mem.wr_data_valid) begin
          wr_take = 1'b1;
          ram_en  = !abort_q;
          ram_we  = 1'b1;
          step    = 1'b1;
          if (last) state_nxt = IDLE;
        end
      end
      AMO_RD: begin
        ram_en    = 1'b1;
        state_nxt = AMO_WR;
      end
      AMO_WR: begin
        if (mem.wr_data_valid) begin
          wr_take   = 1'b1;
          ram_en    = !abort_q;
          ram_we    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      wr_take   = 1'b0;
      ram_en    = 1'b0;
      step      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      be_q     <= '0;
      abort_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
    end else begin
      state    <= state_nxt;
      rd_vld_q <= ram_en && !ram_we;
      if (ram_en && !ram_we) rd_id_q <= id_q;
      if (pop) begin
        addr_q  <= mem.addr[AW-1:0];
        size_q  <= mem.is_amo ? '0 : mem.amo_type_or_burst_size;
        cnt_q   <= '0;
        id_q    <= mem.id;
        be_q    <= mem.be;
        abort_q <= mem.abort;
      end else if (step) begin
        // Word address wraps naturally at the array size.
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  l2_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (mem.wr_data),
    .rdata (ram_rdata)
  );

  assign mem.request_pop   = pop;
  assign mem.wr_data_read  = wr_take;
  assign mem.rd_data       = ram_rdata;
  assign mem.rd_id         = rd_id_q;
  assign mem.rd_data_valid = rd_vld_q;

endmodule

// File: doc/l2_sram_responder.md
L2_SRAM_RESPONDER -- requirements
Module: l2_sram_responder

Interface
REQ-001 Parameter: L2_ID_W, default $clog2(L2_NUM_PORTS)+L2_SUB_ID_W, width of request and response ids.
REQ-002 Parameter: DEPTH_WORDS, default 4096, number of 32-bit words in the backing array (power of two).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: mem  l2_memory_interface.slave  --  responder end of the L2 memory protocol. Members:
- addr/be/rnw/is_amo/amo_type_or_burst_size/id (in)
- request_valid/abort (in); request_pop (out)
- wr_data/wr_data_valid (in); wr_data_read (out)
- rd_data/rd_id/rd_data_valid (out)

Function
REQ-006 States SHALL be IDLE, READ, WRITE, AMO_RD, AMO_WR.
REQ-007 request_pop SHALL assert combinationally only in IDLE with request_valid=1; request fields are latched that cycle.
REQ-008 Burst length SHALL be amo_type_or_burst_size+1 words (1..32) for non-AMO requests; AMO requests are always one word.
REQ-009 Word address SHALL be addr[$clog2(DEPTH_WORDS)-1:0], incremented by one per burst word, wrapping modulo DEPTH_WORDS.
REQ-010 Pop with abort=0, rnw=1, is_amo=0: IDLE->READ; one array read per cycle in READ; READ->IDLE in the cycle the last word is issued.
REQ-011 rd_data_valid SHALL be registered, asserting exactly one cycle after each array read, with rd_data = word and rd_id = latched id; no backpressure exists.
REQ-012 Pop with abort=0, rnw=0, is_amo=0: IDLE->WRITE; each cycle with wr_data_valid=1 SHALL assert wr_data_read combinationally and write wr_data under latched be. After the last word: WRITE->IDLE.
REQ-013 Pop with is_amo=1, abort=0: IDLE->AMO_RD (read old word, returned per REQ-011) -> AMO_WR. AMO_WR waits for wr_data_valid, then writes wr_data under be and returns to IDLE (swap semantics).
REQ-014 Pop with abort=1: no array access, no rd_data_valid. If rnw=0 or is_amo=1, the burst's wr_data words SHALL still be consumed via WRITE/AMO_WR with array writes suppressed.
REQ-015 A new request MAY be popped in the cycle the final read word of the previous burst is presented on rd_data (back-to-back throughput).
REQ-016 Byte lanes with be[i]=0 SHALL leave array byte i unchanged.
REQ-017 wr_data_valid in IDLE/READ/AMO_RD SHALL be ignored (wr_data_read=0).

Reset
REQ-018 On rst: state=IDLE; burst counter=0; rd_data_valid=0; request_pop=0; wr_data_read=0; rd_data/rd_id=0.
REQ-019 Reset mid-burst SHALL abandon the burst; rd_data_valid=0 from the cycle after rst is sampled. Array contents are not reset.

Structure
REQ-020 The state enum typedef SHALL live in l2_config_and_types beside L2_NUM_PORTS and L2_SUB_ID_W.
REQ-021 Backing storage SHALL be a sub-module l2_sram_bank: single-port, byte-enable write, registered 1-cycle read.
REQ-022 Burst counter SHALL be 5 bits; last word is detected when counter == latched burst size.

Verification
REQ-023 Read burst: addr=0x10, burst_size=3, id=5 after preload 0xA0..0xA3 -> pop in cycle 0; rd_data_valid cycles 2..5 with data 0xA0..0xA3, rd_id=5.
REQ-024 Write: addr=0x20, burst_size=1, be=4'b0011, wr_data 0x11112222 then 0x33334444 over word 0xFFFFFFFF -> words 0xFFFF2222, 0xFFFF4444; two wr_data_read pulses.
REQ-025 AMO swap at 0x30 holding 0x5 with wr_data 0x9 -> rd_data 0x5 returned once; word reads 0x9 afterward.
REQ-026 Aborted write: abort=1, burst_size=2 -> three wr_data_read pulses; memory unchanged; no rd_data_valid.
REQ-027 Wrap plus back-to-back: read at DEPTH_WORDS-1, burst_size=1 -> words [DEPTH-1], [0]. Second request popped in the cycle the final word is valid.
REQ-028 Reset asserted mid 8-word read after 3 words -> rd_data_valid=0 from the next cycle; state IDLE; next request serviced normally.
